// File: rtl/graph_coloring_checker_seq_if.sv
// Bundle of the color-table write port, the edge stream handshake and the
// result signals of the sequential graph-coloring checker.
interface graph_coloring_checker_seq_if #(
    parameter int VID_W   = 3,
    parameter int COLOR_W = 2,
    parameter int CNT_W   = 8
);
    logic               col_we;
    logic [VID_W-1:0]   col_addr;
    logic [COLOR_W-1:0] col_data;
    logic               start;
    logic               edge_valid;
    logic               edge_ready;
    logic [VID_W-1:0]   edge_u;
    logic [VID_W-1:0]   edge_v;
    logic               edge_last;
    logic               busy;
    logic               done;
    logic               proper;
    logic [CNT_W-1:0]   conflict_cnt;
    logic [VID_W-1:0]   first_bad_u;
    logic [VID_W-1:0]   first_bad_v;
    logic               bad_vid;

    modport master (
        output col_we, col_addr, col_data, start,
        output edge_valid, edge_u, edge_v, edge_last,
        input  edge_ready, busy, done, proper, conflict_cnt,
        input  first_bad_u, first_bad_v, bad_vid
    );

    modport slave (
        input  col_we, col_addr, col_data, start,
        input  edge_valid, edge_u, edge_v, edge_last,
        output edge_ready, busy, done, proper, conflict_cnt,
        output first_bad_u, first_bad_v, bad_vid
    );
endinterface

// File: rtl/graph_coloring_checker_seq.sv
// Sequential proper-coloring checker: a vertex color table is loaded while
// idle, then an edge list is streamed one edge per cycle and every edge whose
// endpoints share a color (or is a self-loop / names a missing vertex) is
// counted as a conflict.
module graph_coloring_checker_seq #(
    parameter int NUM_V   = 6,
    parameter int COLOR_W = 2,
    parameter int VID_W   = 3,
    parameter int CNT_W   = 8
) (
    input logic clk,
    input logic rst,
    graph_coloring_checker_seq_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    // The table spans the whole id space so any id indexes it safely; entries
    // at or above NUM_V are constant zero and never written.
    localparam int TBL_N = 1 << VID_W;
    localparam logic [VID_W:0] NUM_V_EXT = (VID_W + 1)'(NUM_V);

    logic [1:0]         state;
    logic [COLOR_W-1:0] color [TBL_N];
    logic [COLOR_W-1:0] color_u;
    logic [COLOR_W-1:0] color_v;
    logic               accept;
    logic               u_oob;
    logic               v_oob;
    logic               is_conflict;
    logic               table_we;
    logic [CNT_W-1:0]   cnt;
    logic [VID_W-1:0]   bad_u;
    logic [VID_W-1:0]   bad_v;
    logic               bad_id;
    logic               proper_flag;

    assign table_we = (state == ST_IDLE) && bus.col_we;

    genvar gi;
    generate
        for (gi = 0; gi < TBL_N; gi++) begin : g_color
            if (gi < NUM_V) begin : g_used
                logic [COLOR_W-1:0] entry;
                // Load this vertex's color while idle; a write sharing the
                // start cycle lands before the first edge is examined.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)
                        entry <= '0;
                    else if (table_we && bus.col_addr == VID_W'(gi))
                        entry <= bus.col_data;
                end
                assign color[gi] = entry;
            end else begin : g_unused
                assign color[gi] = '0;
            end
        end
    endgenerate

    assign accept      = bus.edge_valid && (state == ST_RUN);
    assign u_oob       = {1'b0, bus.edge_u} >= NUM_V_EXT;
    assign v_oob       = {1'b0, bus.edge_v} >= NUM_V_EXT;
    assign color_u     = color[bus.edge_u];
    assign color_v     = color[bus.edge_v];
    assign is_conflict = u_oob || v_oob || (bus.edge_u == bus.edge_v) || (color_u == color_v);

    // Run control: IDLE -> RUN on start, RUN -> REPORT on the accepted last
    // edge, REPORT lasts a single cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (bus.start) state <= ST_RUN;
                ST_RUN:    if (accept && bus.edge_last) state <= ST_REPORT;
                ST_REPORT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Result bookkeeping: cleared on start, updated per accepted edge, held
    // afterwards. proper is settled on the final edge so it is valid with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            bad_u       <= '0;
            bad_v       <= '0;
            bad_id      <= 1'b0;
            proper_flag <= 1'b0;
        end else if (state == ST_IDLE && bus.start) begin
            cnt         <= '0;
            bad_u       <= '0;
            bad_v       <= '0;
            bad_id      <= 1'b0;
            proper_flag <= 1'b0;
        end else if (accept) begin
            if (is_conflict) begin
                if (cnt != {CNT_W{1'b1}})
                    cnt <= cnt + CNT_W'(1);
                // A zero count means no earlier conflict in this run.
                if (cnt == '0) begin
                    bad_u <= bus.edge_u;
                    bad_v <= bus.edge_v;
                end
                if (u_oob || v_oob)
                    bad_id <= 1'b1;
            end
            if (bus.edge_last)
                proper_flag <= (cnt == '0) && !is_conflict;
        end
    end

    assign bus.edge_ready   = (state == ST_RUN);
    assign bus.busy         = (state != ST_IDLE);
    assign bus.done         = (state == ST_REPORT);
    assign bus.proper       = proper_flag;
    assign bus.conflict_cnt = cnt;
    assign bus.first_bad_u  = bad_u;
    assign bus.first_bad_v  = bad_v;
    assign bus.bad_vid      = bad_id;
endmodule
